pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised pipeline-stage register with valid/ready handshake, replacing fixed per-stage latches (id_ex, ex_mem, ...).
//  Sits between two pipeline stages and carries one packed stage payload (rd/load/store/addr/value fields).
//  A 2-entry skid buffer keeps full throughput under downstream back-pressure. A flush kills in-flight entries.
//  A saturating counter reports cycles lost to back-pressure, for performance analysis.
// PARAMETERS
//  WIDTH    70     payload width in bits (packed stage fields)
//  NOP_VAL  0      payload value driven while no valid entry is present (NOP encoding)
//  SKID_EN  1      1: 2-entry skid buffer; 0: single register with in_ready_out = !valid | out_ready_in
//  CNT_W    16     width of the back-pressure stall counter
// PORTS
//  clk_in          in   1      clock, rising edge
//  rst_n_in        in   1      asynchronous reset, active low
//  rdy_in          in   1      global enable; 0 freezes every register (clock-gate equivalent)
//  flush_in        in   1      synchronous kill of all held entries (branch mispredict)
//  in_valid_in     in   1      upstream payload valid
//  in_data_in      in   WIDTH  upstream payload
//  in_ready_out    out  1      stage can accept this cycle
//  out_valid_out   out  1      downstream payload valid
//  out_data_out    out  WIDTH  downstream payload; NOP_VAL when out_valid_out = 0
//  out_ready_in    in   1      downstream accepts this cycle
//  stall_cnt_out   out  CNT_W  saturating count of cycles with out_valid_out & !out_ready_in
// BEHAVIOUR
//  Reset: asynchronous and active low. Both valid bits = 0 and both data registers = NOP_VAL.
//   State = EMPTY, in_ready_out = 1, out_valid_out = 0, out_data_out = NOP_VAL, stall_cnt_out = 0.
//  Transfer rules:
//   - Upstream transfer: in_valid_in & in_ready_out.
//   - Downstream transfer: out_valid_out & out_ready_in.
//   - Latency is 1 cycle from input to output. Throughput is 1 per cycle.
//  SKID_EN=1: in_ready_out = !skid_valid. It is a registered signal with no combinational path from out_ready_in.
//   FSM (main_valid, skid_valid):
//    EMPTY: accept                        -> FULL, main <= in
//    FULL : accept & out_ready_in         -> FULL, main <= in
//           accept & !out_ready_in        -> SKID, skid <= in, main held
//           !accept & out_ready_in        -> EMPTY
//           otherwise                     -> stay
//    SKID : out_ready_in                  -> FULL, main <= skid (no accept, because in_ready_out = 0)
//           otherwise                     -> stay, all data held
//  SKID_EN=0: single register. in_ready_out = !main_valid | out_ready_in, which is a combinational pass-through.
//  Ordering: entries always leave in arrival order. The skid entry is never overtaken.
//  flush_in = 1: next state = EMPTY and both data registers <= NOP_VAL.
//   - flush_in wins over a same-cycle upstream transfer; the incoming payload is dropped.
//   - A downstream transfer in the flush cycle still completes, since out_* show the old value in that cycle.
//  rdy_in = 0: all state, data and the counter hold. Outputs stay stable. Handshakes are not evaluated.
//  Stall counter: increments on each rdy_in cycle with out_valid_out & !out_ready_in.
//   - It saturates at 2^CNT_W-1 and never wraps.
//   - It is not cleared by flush; only reset clears it.
//  out_data_out equals main data when main_valid = 1, else NOP_VAL. Data is never X after reset.
//  Reset mid-transfer: all state is lost at once. Upstream must re-send, as in_ready_out returns to 1.
// STRUCTURE
//  Add to defines.v:
//   - state encodings `PipeEmpty/`PipeFull/`PipeSkid (2 bits).
//   - `StallCntW.
//   - A per-stage `ExMemPayloadW plus field-offset macros for packing rd/load/store/addr/value.
//   - The existing NOP macros (`NOPRegAdder, `NOPInstType, `ZeroWord) build NOP_VAL.
//  Sub-module: pipe_sat_counter (CNT_W, inc, en, saturating).
//  Existing ex_mem-style wrappers become thin packers around one pipe_stage_buf instance.
// TESTING
//  1. Reset then in_valid=1, data 0x11,0x22,0x33 on consecutive cycles, out_ready=1
//     -> out 0x11,0x22,0x33 one cycle later each; in_ready stays 1; stall_cnt=0.
//  2. FULL with 0xA; out_ready=0 while 0xB arrives
//     -> SKID, in_ready=0. Next cycle out_ready=1 -> out 0xA then 0xB, in order; stall_cnt=1.
//  3. SKID state with flush_in=1 and in_valid=1 (0xC)
//     -> next cycle out_valid=0, out_data=NOP_VAL, in_ready=1; 0xC is never emitted.
//  4. rdy_in=0 for 5 cycles mid-stream with out_ready=0
//     -> outputs, state and stall_cnt are unchanged over all 5 cycles.
//  5. CNT_W=4 with out_ready held at 0 for 20 cycles
//     -> stall_cnt reaches 15 and stays at 15.
//  6. Assert rst_n_in low asynchronously between edges while in SKID
//     -> out_valid=0, out_data=NOP_VAL and in_ready=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf_pkg
//  Shared types and constants for the generic pipeline-stage buffer.
//   - pipe_state_e     : buffer occupancy state (EMPTY / FULL / SKID)
//   - STALL_CNT_W      : default width of the back-pressure stall counter
//   - ex_mem_payload_t : packed EX->MEM stage payload (70 bits)
//   - EX_MEM_NOP       : NOP encoding of that payload
//   - ex_mem_pack()    : helper that packs the individual stage fields
// ----------------------------------------------------------------------------
package pipe_stage_buf_pkg;

    // Bit 0 is main_valid and bit 1 is skid_valid, so the encoding doubles as
    // the valid-bit pair.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_FULL  = 2'b01,
        PIPE_SKID  = 2'b11
    } pipe_state_e;

    localparam int STALL_CNT_W = 16;

    // NOP building blocks for stage payloads.
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic        NOP_INST_TYPE = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0;

    // EX->MEM payload. addr is a word address, so its two low bits are dropped.
    typedef struct packed {
        logic        wreg;
        logic        store;
        logic        load;
        logic [4:0]  rd;
        logic [29:0] addr;
        logic [31:0] value;
    } ex_mem_payload_t;

    localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    localparam ex_mem_payload_t EX_MEM_NOP = '{
        wreg  : NOP_INST_TYPE,
        store : NOP_INST_TYPE,
        load  : NOP_INST_TYPE,
        rd    : NOP_REG_ADDR,
        addr  : ZERO_WORD[31:2],
        value : ZERO_WORD
    };

    function automatic ex_mem_payload_t ex_mem_pack(
        input logic        wreg,
        input logic        store,
        input logic        load,
        input logic [4:0]  rd,
        input logic [31:0] byte_addr,
        input logic [31:0] value
    );
        ex_mem_payload_t p;
        p.wreg  = wreg;
        p.store = store;
        p.load  = load;
        p.rd    = rd;
        p.addr  = byte_addr[31:2];
        p.value = value;
        return p;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// ----------------------------------------------------------------------------
// pipe_sat_counter
//  Saturating up-counter: counts inc_in pulses while en_in is high, sticks at
//  all-ones and never wraps. Only reset clears it.
//  Ports:
//   clk_in   in  1      clock, rising edge
//   rst_n_in in  1      asynchronous reset, active low
//   en_in    in  1      global enable (0 holds the count)
//   inc_in   in  1      increment request
//   cnt_out  out CNT_W  current count
// ----------------------------------------------------------------------------
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic             inc_in,
    output logic [CNT_W-1:0] cnt_out
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            cnt_out <= '0;
        else if (en_in && inc_in && (cnt_out != {CNT_W{1'b1}}))
            cnt_out <= cnt_out + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
//  Generic pipeline-stage register with valid/ready handshake. With SKID_EN=1
//  a 2-entry skid buffer gives full throughput under back-pressure while
//  in_ready_out stays a pure register output. flush_in drops every held entry;
//  a saturating counter reports cycles lost to downstream back-pressure.
//  Ports:
//   clk_in         in  1      clock, rising edge
//   rst_n_in       in  1      asynchronous reset, active low
//   rdy_in         in  1      global enable; 0 freezes all registers
//   flush_in       in  1      synchronous kill of held entries
//   in_valid_in    in  1      upstream valid
//   in_data_in     in  WIDTH  upstream payload
//   in_ready_out   out 1      stage can accept this cycle
//   out_valid_out  out 1      downstream valid
//   out_data_out   out WIDTH  downstream payload (NOP_VAL when not valid)
//   out_ready_in   in  1      downstream accepts this cycle
//   stall_cnt_out  out CNT_W  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH   = 70,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter bit               SKID_EN = 1'b1,
    parameter int               CNT_W   = STALL_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    input  logic [WIDTH-1:0] in_data_in,
    output logic             in_ready_out,
    output logic             out_valid_out,
    output logic [WIDTH-1:0] out_data_out,
    input  logic             out_ready_in,
    output logic [CNT_W-1:0] stall_cnt_out
);

    pipe_state_e      state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;

    assign main_valid = state[0];
    assign skid_valid = state[1];

    // Skid mode keeps in_ready a register output; without the skid entry the
    // stage can only refill in the same cycle it drains.
    assign in_ready_out  = SKID_EN ? !skid_valid : (!main_valid || out_ready_in);
    assign accept        = in_valid_in && in_ready_out;
    assign out_valid_out = main_valid;
    assign out_data_out  = main_valid ? main_data : NOP_VAL;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= PIPE_EMPTY;
            main_data <= NOP_VAL;
            skid_data <= NOP_VAL;
        end else if (rdy_in) begin
            if (flush_in) begin
                // The incoming beat is dropped; a downstream handshake in this
                // cycle still completes since out_* show the old entry.
                state     <= PIPE_EMPTY;
                main_data <= NOP_VAL;
                skid_data <= NOP_VAL;
            end else begin
                unique case (state)
                    PIPE_EMPTY: begin
                        if (accept) begin
                            main_data <= in_data_in;
                            state     <= PIPE_FULL;
                        end
                    end
                    PIPE_FULL: begin
                        if (accept && out_ready_in) begin
                            main_data <= in_data_in;
                        end else if (accept) begin
                            // Only reachable with SKID_EN: park the newcomer
                            // behind the stalled head.
                            skid_data <= in_data_in;
                            state     <= PIPE_SKID;
                        end else if (out_ready_in) begin
                            state     <= PIPE_EMPTY;
                        end
                    end
                    PIPE_SKID: begin
                        // in_ready_out is 0 here, so nothing new can arrive.
                        if (out_ready_in) begin
                            main_data <= skid_data;
                            state     <= PIPE_FULL;
                        end
                    end
                    default: begin
                        state <= PIPE_EMPTY;
                    end
                endcase
            end
        end
    end

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en_in    (rdy_in),
        .inc_in   (out_valid_out && !out_ready_in),
        .cnt_out  (stall_cnt_out)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int         W     = 70;
    localparam int         CW    = 4;
    localparam logic [W-1:0] NOP = 70'h1_5A5A_5A5A_5A5A_5A5A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]  exp_q[$];
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .WIDTH  (W),
        .NOP_VAL(NOP),
        .SKID_EN(1'b1),
        .CNT_W  (CW)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rdy_in        (rdy),
        .flush_in      (flush),
        .in_valid_in   (in_valid),
        .in_data_in    (in_data),
        .in_ready_out  (in_ready),
        .out_valid_out (out_valid),
        .out_data_out  (out_data),
        .out_ready_in  (out_ready),
        .stall_cnt_out (cnt)
    );

    // One clock cycle. At the falling edge the scoreboard checks the current
    // outputs against the reference queue, then applies the handshakes that
    // the next rising edge will perform. Returns 1 time unit after that edge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = '0;
        end else begin
            n_tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_out_valid: got %b want %b", out_valid, exp_q.size() != 0);
            end
            n_tests++;
            if (in_ready !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %b", in_ready, exp_q.size() < 2);
            end
            n_tests++;
            if (cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL sb_stall_cnt: got %0d want %0d", cnt, exp_cnt);
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                if (out_data !== NOP) begin
                    n_fail++;
                    $display("FAIL sb_nop_data: got %h want %h", out_data, NOP);
                end
            end
            if (rdy) begin
                acc = in_valid && (exp_q.size() < 2);
                if (exp_q.size() != 0 && !out_ready && exp_cnt != {CW{1'b1}})
                    exp_cnt = exp_cnt + 1'b1;
                if (exp_q.size() != 0 && out_ready) begin
                    n_tests++;
                    if (out_data !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL sb_out_data: got %h want %h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (flush)
                    exp_q.delete();
                else if (acc)
                    exp_q.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        rdy       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== NOP || cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h cnt=%0d want 1 0 %h 0",
                     in_ready, out_valid, out_data, cnt, NOP);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [W-1:0] vals[3];
        vals[0] = 70'h11; vals[1] = 70'h22; vals[2] = 70'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: vld=%b data=%h rdy=%b want 1 %h 1",
                         i, out_valid, out_data, in_ready, vals[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || cnt !== '0) begin
            n_fail++;
            $display("FAIL stream_end: vld=%b cnt=%0d want 0 0", out_valid, cnt);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 70'hA;
        tick();
        in_data = 70'hB;
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_data !== 70'hA || cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL skid_hold: rdy=%b data=%h cnt=%0d want 0 a 1", in_ready, out_data, cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 70'hB || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_order: vld=%b data=%h rdy=%b want 1 b 1", out_valid, out_data, in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL skid_drain: vld=%b cnt=%0d want 0 1", out_valid, cnt);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 70'hD;
        tick();
        in_data = 70'hE;
        tick();
        flush   = 1'b1;
        in_data = 70'hC;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_kill: vld=%b data=%h rdy=%b want 0 %h 1", out_valid, out_data, in_ready, NOP);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_emit_%0d: vld=%b data=%h want 0", i, out_valid, out_data);
            end
        end
        n_tests++;
        if (cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL flush_cnt_kept: cnt=%0d want 2", cnt);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 70'h44;
        tick();
        in_valid = 1'b0;
        tick();
        rdy      = 1'b0;
        in_valid = 1'b1;
        in_data  = 70'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 70'h44 || in_ready !== 1'b1 || cnt !== 4'd1) begin
                n_fail++;
                $display("FAIL freeze_%0d: vld=%b data=%h rdy=%b cnt=%0d want 1 44 1 1",
                         i, out_valid, out_data, in_ready, cnt);
            end
        end
        rdy = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL freeze_resume: rdy=%b cnt=%0d want 0 2", in_ready, cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_saturate();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 70'h66;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_tests++;
            if (cnt !== CW'((k > 15) ? 15 : k)) begin
                n_fail++;
                $display("FAIL saturate_%0d: cnt=%0d want %0d", k, cnt, (k > 15) ? 15 : k);
            end
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 70'h77;
        tick();
        in_data = 70'h88;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== NOP || in_ready !== 1'b1 || cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: vld=%b data=%h rdy=%b cnt=%0d want 0 %h 1 0",
                     out_valid, out_data, in_ready, cnt, NOP);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rdy       = ($urandom_range(0, 9) != 0);
            in_data   = {6'($urandom), $urandom, $urandom};
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rdy       = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: left=%0d vld=%b want 0 0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_freeze();
        test_saturate();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
